// File: rtl/sa_step_driver_if.sv
// Handshake bundle between the SA instruction decode and the step driver.
// The controller side uses master and the step driver uses slave.
`ifndef SA_COUNTER_WIDTH
`define SA_COUNTER_WIDTH 4
`endif

interface sa_step_driver_if #(
    parameter int BIT_WIDTH = `SA_COUNTER_WIDTH,
    parameter int GAP_W     = 4
);
    logic                 start;
    logic [BIT_WIDTH:0]   num_steps;
    logic [GAP_W-1:0]     gap;
    logic                 stall;
    logic                 abort;
    logic                 busy;
    logic                 step;
    logic                 last;
    logic [BIT_WIDTH:0]   remaining;
    logic                 done;

    modport master (
        output start, num_steps, gap, stall, abort,
        input  busy, step, last, remaining, done
    );

    modport slave (
        input  start, num_steps, gap, stall, abort,
        output busy, step, last, remaining, done
    );
endinterface

// File: rtl/sa_step_driver.sv
// Issues a programmed burst of single-cycle step pulses (counter3.inc) with
// optional inter-step gaps, stall back-pressure, abort and a closing done pulse.
`ifndef SA_COUNTER_WIDTH
`define SA_COUNTER_WIDTH 4
`endif

module sa_step_driver #(
    parameter int BIT_WIDTH = `SA_COUNTER_WIDTH,
    parameter int GAP_W     = 4
) (
    input  logic              clk,
    input  logic              rstn,
    sa_step_driver_if.slave   bus
);
    localparam int CW = BIT_WIDTH + 1;

    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE  = {{BIT_WIDTH{1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
    localparam logic [GAP_W-1:0] GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    remaining_q, remaining_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [GAP_W-1:0] gap_lat_q, gap_lat_d;
    logic             busy_s, step_s, last_s, done_s;

    // Next-state and output decode; abort always wins over step and done.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        gap_cnt_d   = gap_cnt_q;
        gap_lat_d   = gap_lat_q;
        busy_s      = 1'b0;
        step_s      = 1'b0;
        last_s      = 1'b0;
        done_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.num_steps != CNT_ZERO) begin
                        remaining_d = bus.num_steps;
                        gap_lat_d   = bus.gap;
                        gap_cnt_d   = GAP_ZERO;
                        state_d     = ST_RUN;
                    end else begin
                        state_d     = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                busy_s = 1'b1;
                if (bus.abort) begin
                    remaining_d = CNT_ZERO;
                    gap_cnt_d   = GAP_ZERO;
                    state_d     = ST_IDLE;
                end else if (gap_cnt_q != GAP_ZERO) begin
                    // The gap drains even while stalled; stall only holds a ready step.
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end else if (!bus.stall) begin
                    step_s      = 1'b1;
                    remaining_d = remaining_q - CNT_ONE;
                    gap_cnt_d   = gap_lat_q;
                    if (remaining_q == CNT_ONE) begin
                        last_s  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                busy_s = 1'b1;
                if (bus.abort) begin
                    remaining_d = CNT_ZERO;
                end else begin
                    done_s = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                remaining_d = CNT_ZERO;
                gap_cnt_d   = GAP_ZERO;
                gap_lat_d   = GAP_ZERO;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            remaining_q <= CNT_ZERO;
            gap_cnt_q   <= GAP_ZERO;
            gap_lat_q   <= GAP_ZERO;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            gap_cnt_q   <= gap_cnt_d;
            gap_lat_q   <= gap_lat_d;
        end
    end

    assign bus.busy      = busy_s;
    assign bus.step      = step_s;
    assign bus.last      = last_s;
    assign bus.done      = done_s;
    assign bus.remaining = remaining_q;
endmodule

// File: tb/tb_sa_step_driver.sv
// Directed, table-driven bench for sa_step_driver with a few hand-written bursts.
module tb_sa_step_driver;
    localparam int BW = 4;
    localparam int CW = BW + 1;
    localparam int GW = 4;

    logic clk = 1'b0;
    logic rstn;

    sa_step_driver_if #(.BIT_WIDTH(BW), .GAP_W(GW)) bus ();

    sa_step_driver #(.BIT_WIDTH(BW), .GAP_W(GW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          start;
        logic [CW-1:0] num;
        logic [GW-1:0] gap;
        logic          stall;
        logic          abort;
        logic          rstn;
        logic          chk;
        logic          busy;
        logic          step;
        logic          last;
        logic [CW-1:0] rem;
        logic          done;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(bit st, int n, int g, bit sl, bit ab, bit rn, bit ck,
                                bit b, bit s, bit l, int r, bit d);
        vec_t v;
        v.start = st;       v.num   = CW'(n);  v.gap  = GW'(g);
        v.stall = sl;       v.abort = ab;      v.rstn = rn;  v.chk = ck;
        v.busy  = b;        v.step  = s;       v.last = l;
        v.rem   = CW'(r);   v.done  = d;
        return v;
    endfunction

    task automatic check_int(string name, int got, int want);
        n_vec++;
        if (got != want) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic run_burst(input int n, input int g);
        int steps = 0, dones = 0, lasts = 0, last_at = -1;
        int prev = -1, bad_gap = 0, cnt3 = 0, seen = 0;
        int budget = n * (g + 1) + 8;
        bus.start = 1'b1; bus.num_steps = CW'(n); bus.gap = GW'(g);
        bus.stall = 1'b0; bus.abort = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (bus.step) begin
                if (prev >= 0 && (c - prev) != g + 1) bad_gap++;
                prev = c;
                steps++;
                cnt3 = (cnt3 == n - 1) ? 0 : cnt3 + 1;
                if (bus.last) begin
                    lasts++;
                    last_at = steps;
                end
            end else if (bus.last) begin
                lasts++;
            end
            if (bus.done) begin
                dones++;
                seen = 1;
                break;
            end
        end
        check_int($sformatf("burst%0d_g%0d_finished", n, g), seen, 1);
        check_int($sformatf("burst%0d_g%0d_steps", n, g), steps, n);
        check_int($sformatf("burst%0d_g%0d_dones", n, g), dones, 1);
        check_int($sformatf("burst%0d_g%0d_lasts", n, g), lasts, 1);
        check_int($sformatf("burst%0d_g%0d_last_on_final", n, g), last_at, n);
        check_int($sformatf("burst%0d_g%0d_spacing_errs", n, g), bad_gap, 0);
        check_int($sformatf("burst%0d_g%0d_counter3", n, g), cnt3, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_int($sformatf("burst%0d_g%0d_idle_after", n, g),
                  int'({bus.busy, bus.step, bus.done, bus.remaining}), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Columns: start num gap stall abort rstn chk | busy step last rem done
        // Reset and idle
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,1,1,1, 0,0,0,0,0));
        // Four back-to-back steps
        tbl.push_back(mk(1,4,0,0,0,1,1, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 1,1,0,4,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 1,1,0,3,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 1,1,0,2,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 1,1,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 1,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,1, 0,0,0,0,0));
        // Gap of two: steps at t, t+3, t+6
        tbl.push_back(mk(1,3,2,0,0,1,1, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 1,1,0,3,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 1,0,0,2,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 1,0,0,2,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 1,1,0,2,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 1,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 1,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 1,1,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 1,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,1, 0,0,0,0,0));
        // Two stall cycles after the first step
        tbl.push_back(mk(1,3,0,0,0,1,1, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 1,1,0,3,0));
        tbl.push_back(mk(0,0,0,1,0,1,1, 1,0,0,2,0));
        tbl.push_back(mk(0,0,0,1,0,1,1, 1,0,0,2,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 1,1,0,2,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 1,1,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 1,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,1, 0,0,0,0,0));
        // Zero-step burst; start in DONE is ignored
        tbl.push_back(mk(1,0,0,0,0,1,1, 0,0,0,0,0));
        tbl.push_back(mk(1,5,0,0,0,1,1, 1,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,1, 0,0,0,0,0));
        // Start while busy leaves remaining and gap untouched
        tbl.push_back(mk(1,2,0,0,0,1,1, 0,0,0,0,0));
        tbl.push_back(mk(1,7,3,0,0,1,1, 1,1,0,2,0));
        tbl.push_back(mk(1,7,3,0,0,1,1, 1,1,1,1,0));
        tbl.push_back(mk(1,7,3,0,0,1,1, 1,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,1, 0,0,0,0,0));
        // Abort after 2 of 5 steps, then a fresh burst
        tbl.push_back(mk(1,5,0,0,0,1,1, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 1,1,0,5,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 1,1,0,4,0));
        tbl.push_back(mk(0,0,0,0,1,1,1, 1,0,0,3,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0,1,1, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 1,1,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 1,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,1, 0,0,0,0,0));
        // Abort in DONE suppresses done
        tbl.push_back(mk(1,1,0,0,0,1,1, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 1,1,1,1,0));
        tbl.push_back(mk(0,0,0,0,1,1,1, 1,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 0,0,0,0,0));
        // Reset mid-burst after 3 of 6 steps
        tbl.push_back(mk(1,6,0,0,0,1,1, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 1,1,0,6,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 1,1,0,5,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 1,1,0,4,0));
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,1, 0,0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            rstn          = tbl[i].rstn;
            bus.start     = tbl[i].start;
            bus.num_steps = tbl[i].num;
            bus.gap       = tbl[i].gap;
            bus.stall     = tbl[i].stall;
            bus.abort     = tbl[i].abort;
            @(negedge clk);
            if (tbl[i].chk) begin
                n_vec++;
                if (bus.busy !== tbl[i].busy || bus.step !== tbl[i].step ||
                    bus.last !== tbl[i].last || bus.remaining !== tbl[i].rem ||
                    bus.done !== tbl[i].done) begin
                    n_miss++;
                    $display("FAIL vec%0d: got busy=%b step=%b last=%b rem=%0d done=%b, want busy=%b step=%b last=%b rem=%0d done=%b",
                             i, bus.busy, bus.step, bus.last, bus.remaining, bus.done,
                             tbl[i].busy, tbl[i].step, tbl[i].last, tbl[i].rem, tbl[i].done);
                end
            end
            @(posedge clk); #1;
        end

        // Whole-burst checks with a counter3 model (max_count = N-1)
        run_burst(4, 0);
        run_burst((1 << CW) - 1, 0);
        run_burst(2, 15);
        run_burst(5, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
